mem_access_unit: RTL and testbench

MEM-stage initiator for the word-wide DataMem of the pipelined MIPS core. It accepts load/store requests from the EX/MEM pipeline register over a valid/ready handshake. It drives DataMem's memread/memwrite/address/writedata and captures readdata. Sub-word stores use read-modify-write, and the unit returns a tagged, sign/zero-extended result to WB.

---
 rtl/mem_access_unit.sv | 174 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-wide DataMem. It accepts one load/store
// request at a time, runs one or two DataMem cycles (read, write, or
// read-modify-write for sub-word stores) and returns a tagged, extended result.
module mem_access_unit #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             memread,
  output logic             memwrite,
  output logic [31:0]      address,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata
);

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RSP,
    S_ERR
  } state_t;

  state_t           state_q;
  op_t              op_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      old_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [31:0]      rsp_data_q;
  logic [TAG_W-1:0] rsp_tag_q;
  op_t              req_op_t;

  assign req_op_t = op_t'(req_op);

  function automatic logic misaligned(op_t op, logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         return (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: return a[0];
      default:              return 1'b0;
    endcase
  endfunction

  // Little-endian lane select followed by sign/zero extension.
  function automatic logic [31:0] load_ext(op_t op, logic [1:0] a, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (op)
      OP_LW:   return w;
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0000, h};
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h000000, b};
      default: return '0;
    endcase
  endfunction

  // Replace the addressed byte/halfword of the old word with the store data.
  function automatic logic [31:0] merge_lane(op_t op, logic [1:0] a, logic [31:0] old,
                                             logic [31:0] wd);
    logic [31:0] r;
    r = old;
    if (op == OP_SH) r[{a[1], 4'b0000} +: 16] = wd[15:0];
    else             r[{a, 3'b000} +: 8]      = wd[7:0];
    return r;
  endfunction

  // Request acceptance is only possible in IDLE and never while reset is held.
  assign req_ready = (state_q == S_IDLE) && !reset;

  // Sequencer: latches the request, walks the DataMem cycles, registers the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LW;
      addr_q      <= '0;
      wdata_q     <= '0;
      tag_q       <= '0;
      old_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op_t;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            tag_q   <= req_tag;
            if (misaligned(req_op_t, req_addr[1:0])) begin
              state_q     <= S_ERR;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_tag_q   <= req_tag;
            end else begin
              case (req_op_t)
                OP_SW:        state_q <= S_WR;
                OP_SH, OP_SB: state_q <= S_RMW_RD;
                default:      state_q <= S_RD;
              endcase
            end
          end
        end
        S_RD: begin
          rsp_data_q  <= load_ext(op_q, addr_q[1:0], readdata);
          rsp_valid_q <= 1'b1;
          rsp_tag_q   <= tag_q;
          state_q     <= S_RSP;
        end
        S_RMW_RD: begin
          old_q   <= readdata;
          state_q <= S_RMW_WR;
        end
        S_WR, S_RMW_WR: begin
          rsp_valid_q <= 1'b1;
          rsp_tag_q   <= tag_q;
          state_q     <= S_RSP;
        end
        S_RSP:   state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // DataMem strobes decoded from state and latched request only.
  always_comb begin
    memread   = (state_q == S_RD) || (state_q == S_RMW_RD);
    memwrite  = (state_q == S_WR) || (state_q == S_RMW_WR);
    address   = '0;
    writedata = '0;
    if (memread || memwrite) address = {2'b00, addr_q[31:2]};
    if (state_q == S_WR)     writedata = wdata_q;
    if (state_q == S_RMW_WR) writedata = merge_lane(op_q, addr_q[1:0], old_q, wdata_q);
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural DataMem plus a byte-level reference
// memory; directed test-plan steps followed by randomized requests.
module tb_mem_access_unit;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             memread;
  logic             memwrite;
  logic [31:0]      address;
  logic [31:0]      writedata;
  logic [31:0]      readdata;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic        bk_we = 1'b0;
  logic [5:0]  bk_idx = '0;
  logic [31:0] bk_val = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err),
    .memread   (memread),
    .memwrite  (memwrite),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata)
  );

  // Bench DataMem: combinational read, write on the rising edge.
  assign readdata = mem[address[5:0]];
  always @(posedge clk) begin
    if (memwrite)   mem[address[5:0]] <= writedata;
    else if (bk_we) mem[bk_idx]       <= bk_val;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model rules, in plain arithmetic on byte addresses.
  function automatic int unsigned op_size(int unsigned op);
    case (op)
      0, 5:    return 4;
      1, 2, 6: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit model_err(int unsigned op, logic [31:0] addr);
    return (addr % op_size(op)) != 0;
  endfunction

  function automatic logic [31:0] model_load(int unsigned op, logic [31:0] addr, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> ((addr % 4) * 8)) & 32'hFF;
    h = (w >> (((addr / 2) % 2) * 16)) & 32'hFFFF;
    case (op)
      0:       return w;
      1:       return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      2:       return h;
      3:       return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      4:       return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_store(int unsigned op, logic [31:0] addr,
                                              logic [31:0] old, logic [31:0] d);
    logic [31:0] mask;
    int unsigned sh;
    if (op == 5) return d;
    if (op == 6) begin
      sh = ((addr / 2) % 2) * 16;
      mask = 32'hFFFF << sh;
    end else begin
      sh = (addr % 4) * 8;
      mask = 32'hFF << sh;
    end
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic poke(input int unsigned idx, input logic [31:0] v);
    @(negedge clk);
    bk_we  = 1'b1;
    bk_idx = idx[5:0];
    bk_val = v;
    ref_mem[idx] = v;
    @(posedge clk);
    #1 bk_we = 1'b0;
  endtask

  // One request: transfer, then watch every cycle until the response.
  task automatic do_req(input int unsigned op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [TAG_W-1:0] tag, output logic [31:0] got);
    int unsigned widx, lat, nrd, nwr, both, badaddr, badwd, exp_lat, exp_rd, exp_wr;
    bit          err;
    logic [31:0] old, exp_wd, exp_data;
    logic [TAG_W-1:0] got_tag;
    logic        got_err;
    widx = int'(addr[7:2]);
    err  = model_err(op, addr);
    old  = ref_mem[widx];
    exp_wd   = model_store(op, addr, old, wd);
    exp_data = (!err && op < 5) ? model_load(op, addr, old) : 32'h0;
    exp_lat  = err ? 1 : ((op >= 6) ? 3 : 2);
    exp_rd   = (!err && (op <= 4 || op >= 6)) ? 1 : 0;
    exp_wr   = (!err && op >= 5) ? 1 : 0;
    lat = 0; nrd = 0; nwr = 0; both = 0; badaddr = 0; badwd = 0;
    got = 32'hDEADBEEF; got_tag = '1; got_err = 1'bx;

    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op[2:0];
    req_addr  = addr;
    req_wdata = wd;
    req_tag   = tag;
    for (int i = 0; i < 5 && !req_ready; i++) @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_tag   = TAG_W'($urandom);
    for (int k = 1; k <= 8; k++) begin
      if (memread && memwrite) both++;
      if (memread) nrd++;
      if (memwrite) begin
        nwr++;
        if (writedata !== exp_wd) badwd++;
      end else if (writedata !== 32'h0) badwd++;
      if ((memread || memwrite) && address !== widx) badaddr++;
      if (rsp_valid) begin
        lat = k;
        got = rsp_data;
        got_tag = rsp_tag;
        got_err = rsp_err;
        break;
      end
      @(negedge clk);
    end
    check("latency", lat, exp_lat);
    check("rsp_data", got, exp_data);
    check("rsp_tag", {27'b0, got_tag}, {27'b0, tag});
    check("rsp_err", {31'b0, got_err}, {31'b0, err});
    check("memread_cycles", nrd, exp_rd);
    check("memwrite_cycles", nwr, exp_wr);
    check("rd_wr_overlap", both, 0);
    check("address", badaddr, 0);
    check("writedata", badwd, 0);
    @(negedge clk);
    check("rsp_pulse_end", {31'b0, rsp_valid}, 32'd0);
    check("ready_after", {31'b0, req_ready}, 32'd1);
    if (!err && op >= 5) ref_mem[widx] = exp_wd;
  endtask

  initial begin
    logic [31:0] got;
    int unsigned bad, saw_wr, saw_rsp;
    reset = 1'b1;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_tag = '0;

    @(negedge clk);
    check("rst_outputs", {rsp_valid, rsp_err, memread, memwrite, req_ready},
          32'd0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_tag", {27'b0, rsp_tag}, 32'h0);
    check("rst_address", address, 32'h0);
    check("rst_writedata", writedata, 32'h0);
    for (int unsigned i = 0; i < 64; i++) poke(i, $urandom);
    @(negedge clk);
    reset = 1'b0;

    // Directed test-plan steps.
    poke(5, 32'd50);
    do_req(0, 32'h14, 32'h0, 5'd3, got);        check("tp_lw", got, 32'd50);
    poke(5, 32'h80FF0032);
    do_req(3, 32'h17, 32'h0, 5'd1, got);        check("tp_lb", got, 32'hFFFFFF80);
    do_req(4, 32'h17, 32'h0, 5'd2, got);        check("tp_lbu", got, 32'h00000080);
    do_req(1, 32'h16, 32'h0, 5'd4, got);        check("tp_lh", got, 32'hFFFF80FF);
    do_req(2, 32'h14, 32'h0, 5'd5, got);        check("tp_lhu", got, 32'h00000032);
    do_req(5, 32'h28, 32'd100, 5'd6, got);      check("tp_sw_rsp", got, 32'h0);
    do_req(0, 32'h28, 32'h0, 5'd7, got);        check("tp_lw_sw", got, 32'd100);
    do_req(6, 32'h2A, 32'h1234ABCD, 5'd8, got);
    check("tp_sh_word", mem[10], 32'hABCD0064);
    do_req(7, 32'h29, 32'h00000077, 5'd9, got);
    check("tp_sb_word", mem[10], 32'hABCD7764);
    do_req(0, 32'h15, 32'h0, 5'd10, got);       check("tp_lw_err", got, 32'h0);
    do_req(6, 32'h2B, 32'h5555, 5'd11, got);    check("tp_sh_err", got, 32'h0);

    // Reset during the read half of a sub-word store.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b111; req_addr = 32'h28; req_wdata = 32'hEE; req_tag = 5'd12;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_rmw_rd", {31'b0, memread}, 32'd1);
    #1 reset = 1'b1;
    #1 check("abort_outputs", {rsp_valid, memread, memwrite, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("ready_after_reset", {31'b0, req_ready}, 32'd1);
    saw_wr = 0; saw_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (memwrite) saw_wr++;
      if (rsp_valid) saw_rsp++;
    end
    check("abort_no_write", saw_wr, 0);
    check("abort_no_rsp", saw_rsp, 0);
    check("abort_word10", mem[10], 32'hABCD7764);

    // Randomized requests against the reference model.
    for (int n = 0; n < 80; n++) begin
      do_req($urandom_range(0, 7), $urandom_range(0, 255), $urandom,
             TAG_W'($urandom), got);
    end

    bad = 0;
    for (int unsigned i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("final_memory", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
